// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_rx
// Purpose  : 8N1 UART receiver that pairs bytes into 16-bit RAM writes and
//            closes each burst with an idle timeout reporting the word count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 50,
    parameter int TIMEOUT_BITS = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        rx_done,
    output logic [15:0] rx_len,
    output logic        frame_err
);

    localparam int c_TIMEOUT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int c_IDLE_W  = $clog2(c_TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(c_TIMEOUT - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_TERM = c_IDLE_W'(c_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [c_CNT_W-1:0]  r_clk_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_hi;
    logic                r_half;
    logic [15:0]         r_wcnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_wr_en;
    logic [15:0]         r_wr_addr;
    logic [15:0]         r_wr_data;
    logic                r_rx_done;
    logic [15:0]         r_rx_len;
    logic                r_frame_err;
    logic                w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_timeout = (r_state == ST_IDLE) && (r_idle_cnt == c_IDLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_hi        <= '0;
            r_half      <= 1'b0;
            r_wcnt      <= '0;
            r_idle_cnt  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 16'd1;
            r_wr_data   <= '0;
            r_rx_done   <= 1'b0;
            r_rx_len    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            // Address 0 is reserved, so the pointer wraps from 0xFFFF to 1.
            if (r_wr_en) begin
                r_wr_addr <= (r_wr_addr == 16'hFFFF) ? 16'd1 : r_wr_addr + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_idle_cnt != c_IDLE_TERM) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_half <= 1'b0;
                        if (r_wcnt != 16'd0) begin
                            r_rx_done <= 1'b1;
                            r_rx_len  <= r_wcnt;
                            r_wcnt    <= 16'd0;
                            r_wr_addr <= 16'd1;
                        end
                    end
                    if (!r_sync2) begin
                        r_state    <= ST_START;
                        r_clk_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (r_clk_cnt == c_HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_clk_cnt == c_BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop-bit so an immediately following start bit is caught.
                    if (r_clk_cnt == c_BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_IDLE;
                        if (r_sync2) begin
                            if (r_half) begin
                                r_wr_data <= {r_hi, r_shift};
                                r_wr_en   <= 1'b1;
                                r_half    <= 1'b0;
                                if (r_wcnt != 16'hFFFF) begin
                                    r_wcnt <= r_wcnt + 16'd1;
                                end
                            end else begin
                                r_hi   <= r_shift;
                                r_half <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_half      <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rx_done   = r_rx_done;
    assign rx_len    = r_rx_len;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_rx
// Purpose  : Scoreboard bench for uart_word_rx using directed UART bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_rx;

    localparam int c_CPB = 50;
    localparam logic [1:0] c_K_WR   = 2'd0;
    localparam logic [1:0] c_K_DONE = 2'd1;
    localparam logic [1:0] c_K_FERR = 2'd2;
    localparam logic [1:0] c_K_NONE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        rx_in;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        rx_done;
    logic [15:0] rx_len;
    logic        frame_err;

    ev_t exp_q[$];
    int  n_tests;
    int  n_fail;

    uart_word_rx #(
        .CLKS_PER_BIT(c_CPB),
        .TIMEOUT_BITS(22)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rx_done   (rx_done),
        .rx_len    (rx_len),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every output pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        ev_t e;
        if (wr_en || rx_done || frame_err) begin
            e = {c_K_NONE, 32'h0};
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_tests++;
            if (wr_en) begin
                if (e.kind != c_K_WR || e.addr != wr_addr || e.data != wr_data || wr_addr == 16'd0) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, required kind=%0d addr=%h data=%h",
                             wr_addr, wr_data, e.kind, e.addr, e.data);
                end
            end else if (rx_done) begin
                if (e.kind != c_K_DONE || e.data != rx_len) begin
                    n_fail++;
                    $display("FAIL rx_done: got rx_len=%0d, required kind=%0d len=%0d",
                             rx_len, e.kind, e.data);
                end
            end else begin
                if (e.kind != c_K_FERR) begin
                    n_fail++;
                    $display("FAIL frame_err: got pulse, required kind=%0d", e.kind);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " wr_en"},     {15'd0, wr_en},     16'd0);
        check({tag, " wr_addr"},   wr_addr,            16'd1);
        check({tag, " wr_data"},   wr_data,            16'd0);
        check({tag, " rx_done"},   {15'd0, rx_done},   16'd0);
        check({tag, " rx_len"},    rx_len,             16'd0);
        check({tag, " frame_err"}, {15'd0, frame_err}, 16'd0);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({c_K_WR, a, d});
    endtask

    task automatic push_done(input logic [15:0] len);
        exp_q.push_back({c_K_DONE, 16'd0, len});
    endtask

    task automatic push_ferr();
        exp_q.push_back({c_K_FERR, 32'd0});
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        rx_in = stop;
        repeat (c_CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        n_tests = 0;
        n_fail  = 0;
        rx_in   = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1200);

        // Normal back-to-back burst
        push_wr(16'd1, 16'h1234);
        push_wr(16'd2, 16'hABCD);
        push_done(16'd2);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        idle(1200);

        // Framing error clears nothing already written and drops the bad byte
        push_ferr();
        push_wr(16'd1, 16'h0102);
        push_done(16'd1);
        send_byte(8'h55, 1'b0);
        idle(2 * c_CPB);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(1200);

        // Odd byte count: trailing byte dropped at timeout
        push_wr(16'd1, 16'hAABB);
        push_done(16'd1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        idle(1200);

        // False start glitch
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        idle(100);
        push_wr(16'd1, 16'h5AA5);
        push_done(16'd1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        idle(1200);

        // Reset during bit 4 of the second byte of a pair
        send_byte(8'h11, 1'b1);
        b = 8'h22;
        rx_in = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        rx_in = b[4];
        repeat (c_CPB / 2) @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(200);
        push_wr(16'd1, 16'h3344);
        push_done(16'd1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(1200);

        // Address wrap from 0xFFFF to 1
        force dut.r_wr_addr = 16'hFFFF;
        @(negedge clk);
        release dut.r_wr_addr;
        @(negedge clk);
        check("preload wr_addr", wr_addr, 16'hFFFF);
        push_wr(16'hFFFF, 16'hDEAD);
        push_wr(16'h0001, 16'hBEEF);
        push_done(16'd2);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(1200);

        check("pending events", 16'(exp_q.size()), 16'd0);
        check("rx_len held", rx_len, 16'd2);
        check("wr_addr after burst", wr_addr, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
